// File: rtl/game_countdown_timer.sv
// -----------------------------------------------------------------------------
// game_countdown_timer
//   Counts a loaded MM:SS value (BCD) down to 00:00 using single-cycle
//   one-second ticks from an external 1 s timer, whose enable it also drives.
//   Feeds the 7-segment display digits and flags time-out to the game
//   controller. Supports start, pause and stop.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start             1-cycle pulse: load load_min_* :00 and run
//   stop              1-cycle pulse: halt to IDLE, digits held
//   pause             level: hold the count while running
//   tick              1-cycle pulse from the 1 s timer
//   load_min_tens/ones BCD minutes sampled on start (digits >9 clamp to 9)
//   timer_enable      enable for the 1 s timer, high only in RUN
//   min_tens..sec_ones current BCD digits
//   running           high in RUN or PAUSE
//   time_up           1-cycle pulse on reaching 00:00
//   warn              low-time indicator
//
// Configuration
//   GAME_TIMER_WARN_EN : when defined, builds the low-time warn blinker
//   (WARN_SECS threshold, toggles every BLINK_TICKS ticks). When undefined
//   warn is tied to 0.
// -----------------------------------------------------------------------------
module game_countdown_timer #(
  parameter int WARN_SECS   = 30,
  parameter int BLINK_TICKS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic       tick,
  input  logic [3:0] load_min_tens,
  input  logic [3:0] load_min_ones,
  output logic       timer_enable,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       time_up,
  output logic       warn
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_EXPIRED} state_t;

  state_t     r_state;
  logic [3:0] r_mt, r_mo, r_st, r_so;
  logic       r_en, r_running, r_time_up;

  logic [3:0] w_mt, w_mo, w_st, w_so;
  logic [3:0] w_ld_mt, w_ld_mo;
  logic       w_zero, w_one, w_ld_zero, w_tick_run;

  function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  assign w_ld_mt    = clamp_bcd(load_min_tens);
  assign w_ld_mo    = clamp_bcd(load_min_ones);
  assign w_ld_zero  = (w_ld_mt == 4'd0) && (w_ld_mo == 4'd0);
  assign w_zero     = (r_mt == 4'd0) && (r_mo == 4'd0) && (r_st == 4'd0) && (r_so == 4'd0);
  assign w_one      = (r_mt == 4'd0) && (r_mo == 4'd0) && (r_st == 4'd0) && (r_so == 4'd1);
  // A tick only counts in RUN and never borrows below 00:00.
  assign w_tick_run = tick && (r_state == S_RUN) && !w_zero;

  // One-second decrement with the BCD borrow chain.
  always_comb begin
    w_mt = r_mt;
    w_mo = r_mo;
    w_st = r_st;
    w_so = r_so;
    if (r_so != 4'd0) begin
      w_so = r_so - 4'd1;
    end else begin
      w_so = 4'd9;
      if (r_st != 4'd0) begin
        w_st = r_st - 4'd1;
      end else begin
        w_st = 4'd5;
        if (r_mo != 4'd0) begin
          w_mo = r_mo - 4'd1;
        end else begin
          w_mo = 4'd9;
          w_mt = r_mt - 4'd1;
        end
      end
    end
  end

  // Control FSM; priority start > stop > tick > pause.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_mt      <= 4'd0;
      r_mo      <= 4'd0;
      r_st      <= 4'd0;
      r_so      <= 4'd0;
      r_en      <= 1'b0;
      r_running <= 1'b0;
      r_time_up <= 1'b0;
    end else begin
      r_time_up <= 1'b0;
      if (start) begin
        r_mt <= w_ld_mt;
        r_mo <= w_ld_mo;
        r_st <= 4'd0;
        r_so <= 4'd0;
        if (w_ld_zero) begin
          r_state   <= S_EXPIRED;
          r_time_up <= 1'b1;
          r_en      <= 1'b0;
          r_running <= 1'b0;
        end else begin
          r_state   <= S_RUN;
          r_en      <= 1'b1;
          r_running <= 1'b1;
        end
      end else if (stop && (r_state != S_IDLE)) begin
        r_state   <= S_IDLE;
        r_en      <= 1'b0;
        r_running <= 1'b0;
      end else if (w_tick_run) begin
        r_mt <= w_mt;
        r_mo <= w_mo;
        r_st <= w_st;
        r_so <= w_so;
        if (w_one) begin
          r_state   <= S_EXPIRED;
          r_time_up <= 1'b1;
          r_en      <= 1'b0;
          r_running <= 1'b0;
        end else if (pause) begin
          // Tick is applied first, then the pause takes effect.
          r_state <= S_PAUSE;
          r_en    <= 1'b0;
        end
      end else if ((r_state == S_RUN) && pause) begin
        r_state <= S_PAUSE;
        r_en    <= 1'b0;
      end else if ((r_state == S_PAUSE) && !pause) begin
        // Re-enabling restarts the 1 s timer, dropping any partial second.
        r_state <= S_RUN;
        r_en    <= 1'b1;
      end
    end
  end

  assign timer_enable = r_en;
  assign running      = r_running;
  assign time_up      = r_time_up;
  assign min_tens     = r_mt;
  assign min_ones     = r_mo;
  assign sec_tens     = r_st;
  assign sec_ones     = r_so;

`ifdef GAME_TIMER_WARN_EN
  logic       r_warn, r_in_win;
  logic [7:0] r_blink_cnt;
  logic       w_dec_in_win;

  function automatic logic [12:0] to_secs(input logic [3:0] mt, input logic [3:0] mo,
                                          input logic [3:0] st, input logic [3:0] so);
    return 13'(mt) * 13'd600 + 13'(mo) * 13'd60 + 13'(st) * 13'd10 + 13'(so);
  endfunction

  assign w_dec_in_win = (to_secs(w_mt, w_mo, w_st, w_so) <= 13'(WARN_SECS));

  // Loads are whole minutes, so only a zero load (EXPIRED) can land in the window
  // for thresholds under a minute; larger thresholds are handled on load too.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_warn      <= 1'b0;
      r_in_win    <= 1'b0;
      r_blink_cnt <= 8'd0;
    end else if (start) begin
      r_blink_cnt <= 8'd0;
      if (w_ld_zero) begin
        r_warn   <= 1'b1;
        r_in_win <= 1'b0;
      end else if (to_secs(w_ld_mt, w_ld_mo, 4'd0, 4'd0) <= 13'(WARN_SECS)) begin
        r_warn   <= 1'b1;
        r_in_win <= 1'b1;
      end else begin
        r_warn   <= 1'b0;
        r_in_win <= 1'b0;
      end
    end else if (stop && (r_state != S_IDLE)) begin
      r_warn   <= 1'b0;
      r_in_win <= 1'b0;
    end else if (w_tick_run) begin
      if (w_one) begin
        r_warn   <= 1'b1;
        r_in_win <= 1'b0;
      end else if (w_dec_in_win) begin
        if (!r_in_win) begin
          r_warn      <= 1'b1;
          r_in_win    <= 1'b1;
          r_blink_cnt <= 8'd0;
        end else if (r_blink_cnt == 8'(BLINK_TICKS - 1)) begin
          r_warn      <= ~r_warn;
          r_blink_cnt <= 8'd0;
        end else begin
          r_blink_cnt <= r_blink_cnt + 8'd1;
        end
      end else begin
        r_warn   <= 1'b0;
        r_in_win <= 1'b0;
      end
    end
  end

  assign warn = r_warn;
`else
  assign warn = 1'b0;
`endif

endmodule
